// File: rtl/div_pkg.sv
// Shared types and constants for the restoring divide unit.
// Imported by the divider top and its datapath helpers.
package div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_WIDTH = 16;

  // Sized for the widest legal operand so one package serves every WIDTH.
  localparam int CNT_W = $clog2(MAX_WIDTH + 1);

  localparam logic [MAX_WIDTH-1:0] DBZ_QUO = '1;

endpackage

// File: rtl/addsub_n.sv
// N-bit ripple add/subtract: sum = a + (b ^ {N{k}}) + k.
// cout=1 on a subtract means the difference is non-negative.
module addsub_n #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         k,
  output logic [N-1:0] sum,
  output logic         cout
);

  always_comb begin
    logic c;
    logic bx;
    c   = k;
    bx  = 1'b0;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      bx     = b[i] ^ k;
      sum[i] = a[i] ^ bx ^ c;
      c      = (a[i] & bx) | (c & (a[i] ^ bx));
    end
    cout = c;
  end

endmodule

// File: rtl/seq_div_restoring.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// start/done handshake; results held until the next accepted start.
module seq_div_restoring
  import div_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  state_t           state;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             cout;
  logic             nonneg;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  assign shifted = {rem, quo[WIDTH-1]};

  addsub_n #(
    .N(WIDTH + 1)
  ) u_sub (
    .a   (shifted),
    .b   ({1'b0, dvs}),
    .k   (1'b1),
    .sum (trial),
    .cout(cout)
  );

  // Both flags agree for in-range operands; sign bit is the primary test.
  assign nonneg = cout & ~trial[WIDTH];
  assign rem_nx = nonneg ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_nx = {quo[WIDTH-2:0], nonneg};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            dvs         <= divisor;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              quotient    <= DBZ_QUO[WIDTH-1:0];
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              rem   <= '0;
              quo   <= dividend;
              cnt   <= '0;
            end
          end
        end
        RUN: begin
          rem <= rem_nx;
          quo <= quo_nx;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            quotient  <= quo_nx;
            remainder <= rem_nx;
            done      <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
